// File: rtl/minmax_pkg.sv
// Shared definitions for the running min/max tracker: data width,
// comparator result codes and the window FSM state encoding.
package minmax_pkg;

    localparam int DATA_W = 4;

    localparam logic [1:0] CMP_EQ = 2'b00;
    localparam logic [1:0] CMP_LT = 2'b01;
    localparam logic [1:0] CMP_GT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Unsigned magnitude compare of a against b, returned as {G,L}.
    function automatic logic [1:0] cmp_code(input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
        logic [1:0] code;
        code = CMP_EQ;
        if (a > b) begin
            code = CMP_GT;
        end else if (a < b) begin
            code = CMP_LT;
        end
        return code;
    endfunction

endpackage

// File: rtl/comparator.sv
// Team 4-bit unsigned magnitude comparator producing the {G,L} code.
module comparator
    import minmax_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [1:0]        code
);

    always_comb begin
        code = cmp_code(a, b);
    end

endmodule

// File: rtl/run_minmax_tracker.sv
// Collects windows of 4-bit samples and reports max, min, count and an
// all-equal flag for each window through a valid/ready result port.
module run_minmax_tracker
    import minmax_pkg::*;
#(
    parameter int WINDOW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_max,
    output logic [DATA_W-1:0] out_min,
    output logic [DATA_W-1:0] out_count,
    output logic              out_all_eq
);

    localparam logic [DATA_W-1:0] CNT_LAST = DATA_W'(WINDOW - 1);
    localparam logic [DATA_W-1:0] CNT_ONE  = DATA_W'(1);

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic              window_fills;
    logic [1:0]        cmp_max;
    logic [1:0]        cmp_min;
    logic [DATA_W-1:0] max_q;
    logic [DATA_W-1:0] min_q;
    logic [DATA_W-1:0] cnt_q;
    logic              all_eq_q;
    logic              out_valid_q;

    comparator u_cmp_max (
        .a    (in_data),
        .b    (max_q),
        .code (cmp_max)
    );

    comparator u_cmp_min (
        .a    (in_data),
        .b    (min_q),
        .code (cmp_min)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The accept that brings cnt up to WINDOW closes the window.
    always_comb begin
        state_next   = state;
        window_fills = accept && (cnt_q == CNT_LAST);
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (flush || window_fills) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // in_ready depends on state alone, keeping out_ready off the input path.
    always_comb begin
        in_ready = (state != ST_DONE);
        accept   = in_valid && in_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q    <= '0;
            min_q    <= '0;
            cnt_q    <= '0;
            all_eq_q <= 1'b0;
        end else if (accept) begin
            if (state == ST_IDLE) begin
                max_q    <= in_data;
                min_q    <= in_data;
                cnt_q    <= CNT_ONE;
                all_eq_q <= 1'b1;
            end else begin
                if (cmp_max == CMP_GT) begin
                    max_q <= in_data;
                end
                if (cmp_min == CMP_LT) begin
                    min_q <= in_data;
                end
                if (cmp_max != CMP_EQ) begin
                    all_eq_q <= 1'b0;
                end
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= (state_next == ST_DONE);
        end
    end

    always_comb begin
        out_valid  = out_valid_q;
        out_max    = max_q;
        out_min    = min_q;
        out_count  = cnt_q;
        out_all_eq = all_eq_q;
    end

endmodule

// File: doc/run_minmax_tracker.md
RUN_MINMAX_TRACKER -- requirements
Module: run_minmax_tracker

Interface
REQ-001 SHALL have parameter WINDOW, default 8, legal 2..15: number of 4-bit samples per result window.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, in_data holds a sample.
REQ-005 SHALL have port in_ready, output, 1, block accepts a sample this cycle.
REQ-006 SHALL have port in_data, input, 4, unsigned sample.
REQ-007 SHALL have port flush, input, 1, single-cycle request to close the current window early.
REQ-008 SHALL have port out_valid, output, 1, result fields valid.
REQ-009 SHALL have port out_ready, input, 1, consumer takes the result.
REQ-010 SHALL have port out_max, output, 4, largest sample in window.
REQ-011 SHALL have port out_min, output, 4, smallest sample in window.
REQ-012 SHALL have port out_count, output, 4, number of samples in window.
REQ-013 SHALL have port out_all_eq, output, 1, every sample in window equal.

Function
REQ-014 SHALL accept a sample only on a cycle where in_valid and in_ready are both 1.
REQ-015 SHALL implement FSM states IDLE, ACCUM, DONE; in_ready = 1 in IDLE and ACCUM, 0 in DONE.
REQ-016 IDLE: an accepted sample SHALL set max = min = sample, cnt = 1, all_eq = 1, next state ACCUM; flush in IDLE SHALL be ignored.
REQ-017 ACCUM: each accepted sample SHALL be compared unsigned against max and min; comparator code {G,L}: 10 = greater, 01 = less, 00 = equal.
REQ-018 ACCUM update: sample > max -> max = sample; sample < min -> min = sample; sample != max (pre-update) or all_eq already 0 -> all_eq = 0; cnt += 1.
REQ-019 ACCUM SHALL go to DONE the cycle after the accept that makes cnt == WINDOW.
REQ-020 flush in ACCUM SHALL go to DONE next cycle; if a sample is accepted in the same cycle it SHALL be included first.
REQ-021 DONE: out_valid = 1; out_max, out_min, out_count, out_all_eq SHALL hold stable until out_valid && out_ready.
REQ-022 out_valid && out_ready SHALL return to IDLE next cycle; in_ready rises that cycle, so no combinational path from out_ready to in_ready.
REQ-023 out_valid SHALL be 0 in IDLE and ACCUM; result fields are don't-care outside DONE but SHALL be driven from registers (no X).
REQ-024 Latency: out_valid asserted exactly one cycle after the closing accept or flush cycle.
REQ-025 flush in DONE SHALL be ignored; in_valid in DONE SHALL be back-pressured, not dropped.
REQ-026 cnt SHALL never exceed WINDOW; no wrap-around.

Reset
REQ-027 rst_n low SHALL asynchronously force state IDLE, in_ready 1, out_valid 0, max 0, min 0, cnt 0, all_eq 0.
REQ-028 Reset mid-window or in DONE SHALL discard the partial/pending result; no output after release until a new window completes.
REQ-029 Reset deassertion SHALL be synchronous to clk; first accept possible on the first edge with rst_n high.

Structure
REQ-030 FSM state encoding, comparator code constants (GT=10, LT=01, EQ=00) and data width 4 SHALL live in a shared package minmax_pkg.
REQ-031 SHALL instantiate two copies of the team's 4-bit magnitude comparator block comparator (sample vs max, sample vs min); no other sub-modules.
REQ-032 All outputs SHALL be registered except in_ready, which decodes from state only.

Verification
REQ-033 WINDOW=8, samples 3,9,1,7,7,2,15,4 back-to-back, out_ready=1 -> one result max=15 min=1 count=8 all_eq=0, out_valid 1 cycle after 8th accept.
REQ-034 Samples 5,5 then flush with 5 in same cycle -> max=5 min=5 count=3 all_eq=1.
REQ-035 Full window complete, out_ready held 0 for 10 cycles with in_valid=1 -> in_ready=0, outputs stable, no samples accepted; release -> IDLE next cycle.
REQ-036 Samples 0 and 15 only, then flush -> max=15 min=0 count=2; flush in IDLE -> no output.
REQ-037 rst_n low after 4 samples of a window -> out_valid stays 0; next 8 samples 6 -> max=min=6 count=8 all_eq=1.
REQ-038 Random in_valid/out_ready stress, 1000 windows, against reference model -> every result matches, no lost or duplicated sample.
